// File: rtl/lcd_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hex_formatter
// Brief    : Snapshots NCH packed channel values on a step edge or refresh
//            request and renders them one nibble per cycle as uppercase ASCII
//            hex at programmable character positions of the LCD string.
//            Pulses cls when the string is complete and counts step edges.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module lcd_hex_formatter #(
  parameter int                     NCH       = 4,
  parameter int                     DIGITS    = 8,
  parameter int                     STR_BYTES = 32,
  parameter logic [NCH*8-1:0]       CH_POS    = {8'd24, 8'd16, 8'd8, 8'd0},
  parameter logic [STR_BYTES*8-1:0] INIT_STR  = "01234567 00 0123f01d01e01m01w01 "
) (
  input  logic                      CCLK,
  input  logic                      rst,
  input  logic                      step,
  input  logic                      refresh,
  input  logic [NCH*DIGITS*4-1:0]   ch_data,
  output logic [STR_BYTES*8-1:0]    strdata,
  output logic                      cls,
  output logic                      busy,
  output logic [7:0]                step_cnt
);

  // Counter widths; a single channel or digit still needs one bit.
  localparam int c_cw = (NCH    > 1) ? $clog2(NCH)    : 1;
  localparam int c_dw = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_cw-1:0] c_last_ch  = c_cw'(NCH - 1);
  localparam logic [c_dw-1:0] c_last_dig = c_dw'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q,   state_d;
  logic                      step_q,    step_d;
  logic                      pending_q, pending_d;
  logic [7:0]                step_cnt_q, step_cnt_d;
  logic [NCH*DIGITS*4-1:0]   snap_q,    snap_d;
  logic [c_cw-1:0]           ch_q,      ch_d;
  logic [c_dw-1:0]           dig_q,     dig_d;
  logic [STR_BYTES*8-1:0]    strdata_q, strdata_d;
  logic                      cls_q,     cls_d;
  logic                      busy_q,    busy_d;

  logic                      w_step_rise;
  logic                      w_trig;
  logic [3:0]                w_nib;
  logic [7:0]                w_base;
  logic [8:0]                w_pos;
  logic [7:0]                w_ascii;

  // Select the current nibble and its target character position.
  always_comb begin
    w_nib  = 4'h0;
    w_base = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == c_cw'(c)) begin
        w_base = CH_POS[c*8 +: 8];
        for (int d = 0; d < DIGITS; d++) begin
          if (dig_q == c_dw'(d)) begin
            w_nib = snap_q[c*DIGITS*4 + (DIGITS-1-d)*4 +: 4];
          end
        end
      end
    end
    // Nine bits so that positions past 255 never wrap back into range.
    w_pos   = {1'b0, w_base} + 9'(dig_q);
    w_ascii = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
  end

  // Next-state logic: edge detect, step counter, conversion sequencing.
  always_comb begin
    w_step_rise = step & ~step_q;
    w_trig      = w_step_rise | refresh;

    state_d    = state_q;
    step_d     = step;
    pending_d  = pending_q;
    step_cnt_d = step_cnt_q + {7'd0, w_step_rise};
    snap_d     = snap_q;
    ch_d       = ch_q;
    dig_d      = dig_q;
    strdata_d  = strdata_q;
    cls_d      = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (w_trig) begin
          snap_d  = ch_data;
          ch_d    = '0;
          dig_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        if (w_trig) begin
          pending_d = 1'b1;
        end
        // Positions at or beyond the string end are simply dropped.
        for (int b = 0; b < STR_BYTES; b++) begin
          if (w_pos == 9'(b)) begin
            strdata_d[(STR_BYTES-1-b)*8 +: 8] = w_ascii;
          end
        end
        if (dig_q == c_last_dig) begin
          dig_d = '0;
          if (ch_q == c_last_ch) begin
            ch_d    = '0;
            cls_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          dig_d = dig_q + 1'b1;
        end
      end

      S_DONE: begin
        // A trigger landing in this very cycle is folded into the re-run.
        if (pending_q | w_trig) begin
          pending_d = 1'b0;
          snap_d    = ch_data;
          ch_d      = '0;
          dig_d     = '0;
          state_d   = S_CONV;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any partial string.
  always_ff @(posedge CCLK) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 1'b0;
      pending_q  <= 1'b0;
      step_cnt_q <= 8'd0;
      snap_q     <= '0;
      ch_q       <= '0;
      dig_q      <= '0;
      strdata_q  <= INIT_STR;
      cls_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pending_q  <= pending_d;
      step_cnt_q <= step_cnt_d;
      snap_q     <= snap_d;
      ch_q       <= ch_d;
      dig_q      <= dig_d;
      strdata_q  <= strdata_d;
      cls_q      <= cls_d;
      busy_q     <= busy_d;
    end
  end

  assign strdata  = strdata_q;
  assign cls      = cls_q;
  assign busy     = busy_q;
  assign step_cnt = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hex_formatter
// Brief    : Directed, table-driven bench for lcd_hex_formatter (default
//            parameters) plus a narrow single-channel instance near the
//            string end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hex_formatter;

  localparam logic [255:0] c_init = "01234567 00 0123f01d01e01m01w01 ";

  logic          CCLK = 1'b0;
  logic          rst;
  logic          step, refresh;
  logic [127:0]  ch_data;
  logic [255:0]  strdata;
  logic          cls, busy;
  logic [7:0]    step_cnt;

  logic          step2, refresh2;
  logic [15:0]   ch_data2;
  logic [255:0]  strdata2;
  logic          cls2, busy2;
  logic [7:0]    step_cnt2;

  always #5 CCLK = ~CCLK;

  lcd_hex_formatter dut (
    .CCLK     (CCLK),
    .rst      (rst),
    .step     (step),
    .refresh  (refresh),
    .ch_data  (ch_data),
    .strdata  (strdata),
    .cls      (cls),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  lcd_hex_formatter #(
    .NCH       (1),
    .DIGITS    (4),
    .STR_BYTES (32),
    .CH_POS    (8'd30),
    .INIT_STR  (c_init)
  ) dut2 (
    .CCLK     (CCLK),
    .rst      (rst),
    .step     (step2),
    .refresh  (refresh2),
    .ch_data  (ch_data2),
    .strdata  (strdata2),
    .cls      (cls2),
    .busy     (busy2),
    .step_cnt (step_cnt2)
  );

  // Free-running cycle index and cls pulse monitors.
  int cyc = 0;
  always @(posedge CCLK) cyc <= cyc + 1;

  int cls_n = 0, cls_last = 0, cls2_n = 0, cls2_last = 0;
  always @(negedge CCLK) begin
    if (cls)  begin cls_n++;  cls_last  = cyc; end
    if (cls2) begin cls2_n++; cls2_last = cyc; end
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CCLK);
      #1;
    end
  endtask

  typedef struct {
    logic [127:0] ch;        // {ch3, ch2, ch1, ch0}
    bit           use_step;
    logic [255:0] exp_str;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int t0, b, b2;

    vecs[0] = '{ch: {32'h0123CDEF, 32'hFFFFFFFF, 32'h00000000, 32'h12ABF0E9}, use_step: 1'b1,
                exp_str: "12ABF0E900000000FFFFFFFF0123CDEF", exp_cnt: 8'd1};
    vecs[1] = '{ch: {32'h9999AAAA, 32'hA5A5A5A5, 32'h01234567, 32'h89ABCDEF}, use_step: 1'b0,
                exp_str: "89ABCDEF01234567A5A5A5A59999AAAA", exp_cnt: 8'd1};
    vecs[2] = '{ch: {32'h90000009, 32'h0000000A, 32'hCAFEF00D, 32'hDEADBEEF}, use_step: 1'b1,
                exp_str: "DEADBEEFCAFEF00D0000000A90000009", exp_cnt: 8'd2};

    rst = 1'b1; step = 1'b0; refresh = 1'b0; ch_data = '0;
    step2 = 1'b0; refresh2 = 1'b0; ch_data2 = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_strdata",  strdata,  c_init);
    check("reset_cls",      cls,      0);
    check("reset_busy",     busy,     0);
    check("reset_step_cnt", step_cnt, 0);
    check("reset_strdata2", strdata2, c_init);

    // Table-driven conversions with latency and counter checks.
    for (int i = 0; i < 3; i++) begin
      b = cls_n;
      ch_data = vecs[i].ch;
      if (vecs[i].use_step) step = 1'b1; else refresh = 1'b1;
      t0 = cyc;
      tick(1);
      step = 1'b0; refresh = 1'b0;
      check($sformatf("v%0d_busy_start", i), busy, 1);
      tick(39);
      check($sformatf("v%0d_cls_count", i),   cls_n - b,     1);
      check($sformatf("v%0d_cls_latency", i), cls_last - t0, 33);
      check($sformatf("v%0d_strdata", i),     strdata,       vecs[i].exp_str);
      check($sformatf("v%0d_step_cnt", i),    step_cnt,      vecs[i].exp_cnt);
      check($sformatf("v%0d_busy_end", i),    busy,          0);
    end

    // Held step counts once and converts once.
    b = cls_n;
    step = 1'b1;
    tick(100);
    step = 1'b0;
    tick(5);
    check("held_cls_count", cls_n - b, 1);
    check("held_step_cnt",  step_cnt,  3);

    // Refreshes during conversion collapse into one re-run sampled in DONE.
    b = cls_n;
    ch_data = {4{32'h11111111}};
    step = 1'b1;
    t0 = cyc;
    tick(1);
    step = 1'b0;
    tick(4);
    refresh = 1'b1; tick(1); refresh = 1'b0;
    tick(3);
    refresh = 1'b1; tick(1); refresh = 1'b0;
    tick(10);
    ch_data = {32'h76543210, 32'hFEDCBA98, 32'h0F1E2D3C, 32'h4B5A6978};
    tick(13);
    check("pend_cls_first", cls, 1);
    tick(1);
    ch_data = '0;
    tick(40);
    check("pend_cls_count",   cls_n - b,     2);
    check("pend_cls_latency", cls_last - t0, 66);
    check("pend_strdata",     strdata,       "4B5A69780F1E2D3CFEDCBA9876543210");
    check("pend_step_cnt",    step_cnt,      4);

    // Narrow channel near string end: overflowing digits are dropped.
    b2 = cls2_n;
    ch_data2 = 16'hBEEF;
    refresh2 = 1'b1;
    t0 = cyc;
    tick(1);
    refresh2 = 1'b0;
    tick(10);
    check("narrow_cls_count",   cls2_n - b2,    1);
    check("narrow_cls_latency", cls2_last - t0, 5);
    check("narrow_strdata",     strdata2,       "01234567 00 0123f01d01e01m01w0BE");

    // 256 step edges wrap the counter.
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step = 1'b1; tick(1);
      step = 1'b0; tick(1);
      if (i == 254) check("wrap_step_cnt_255", step_cnt, 255);
    end
    check("wrap_step_cnt_0", step_cnt, 0);
    tick(80);
    check("wrap_idle", busy, 0);
    check("wrap_strdata", strdata, {32{8'h30}});

    // Reset mid-conversion discards the partial string and the pulse.
    b = cls_n;
    ch_data = {4{32'hABCDABCD}};
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(9);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("abort_strdata",  strdata,  c_init);
    check("abort_busy",     busy,     0);
    check("abort_step_cnt", step_cnt, 0);
    tick(40);
    check("abort_no_cls", cls_n - b, 0);
    check("abort_strdata_late", strdata, c_init);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
